rst_seq_ctr: RTL and testbench

Parametrised reset sequencer that turns a raw MMCM lock indication into NUM_CH staggered, active-high reset outputs for the downstream clock domains. It filters lock, holds every channel in reset for a minimum time, and releases channels one by one at fixed spacing. It re-asserts all channels on lock loss or a software request, and counts lock-loss events. It sits beside the clock wizard in the clock/reset controller and replaces the single fixed power-on reset counter.

---
 rtl/rst_seq_ctr_if.sv | 22 ++
 rtl/rst_seq_ctr.sv | 131 +++++++++++++
 tb/tb_rst_seq_ctr.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctr_if.sv
// Bundle of the rst_seq_ctr lock/request inputs and its reset/status outputs.
// The master drives lock and request; the slave (the sequencer) drives resets and status.
interface rst_seq_ctr_if #(
   parameter int NUM_CH = 3
);
   logic              mmc_lock;
   logic              sw_rst_req;
   logic [NUM_CH-1:0] ch_rst;
   logic              seq_done;
   logic [7:0]        lock_lost_cnt;
   logic [1:0]        state_o;

   modport master (
      output mmc_lock, sw_rst_req,
      input  ch_rst, seq_done, lock_lost_cnt, state_o
   );

   modport slave (
      input  mmc_lock, sw_rst_req,
      output ch_rst, seq_done, lock_lost_cnt, state_o
   );
endinterface

// File: rtl/rst_seq_ctr.sv
// Staggered reset sequencer: filters MMCM lock, holds all channels, then releases them one per STEP_DLY.
// All outputs registered; lock loss reaches ch_rst 3 edges after the pin, sw_rst_req 1 edge after sampling.
module rst_seq_ctr #(
   parameter int NUM_CH     = 3,
   parameter int MIN_ASSERT = 16,
   parameter int LOCK_FILT  = 256,
   parameter int STEP_DLY   = 64,
   parameter int CNT_W      = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   rst_seq_ctr_if.slave  bus
);
   localparam int K_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] MA_LAST = CNT_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILT - 1);
   localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STEP_DLY - 1);
   localparam logic [K_W-1:0]   K_LAST  = K_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_ASSERT    = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic              sync1, lock_s;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [K_W-1:0]    k, k_nxt;
   logic [NUM_CH-1:0] ch_rst_q, ch_rst_nxt;
   logic              seq_done_q, seq_done_nxt;
   logic [7:0]        lost_q, lost_nxt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= bus.mmc_lock;
         lock_s <= sync1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_ASSERT;
         cnt        <= '0;
         k          <= '0;
         ch_rst_q   <= '1;
         seq_done_q <= 1'b0;
         lost_q     <= 8'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         k          <= k_nxt;
         ch_rst_q   <= ch_rst_nxt;
         seq_done_q <= seq_done_nxt;
         lost_q     <= lost_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      k_nxt        = k;
      ch_rst_nxt   = ch_rst_q;
      seq_done_nxt = 1'b0;
      lost_nxt     = lost_q;
      case (state)
         ST_ASSERT: begin
            if (bus.sw_rst_req) begin
               cnt_nxt = '0;
            end else if (cnt == MA_LAST) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (bus.sw_rst_req) begin
               state_nxt = ST_ASSERT;
               cnt_nxt   = '0;
            end else if (!lock_s) begin
               cnt_nxt = '0;
            end else if (cnt == LF_LAST) begin
               state_nxt = ST_RELEASE;
               cnt_nxt   = '0;
               k_nxt     = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_RELEASE, ST_RUN: begin
            // Lock loss wins over a coincident software request so it is always counted.
            if (!lock_s) begin
               state_nxt = ST_ASSERT;
               cnt_nxt   = '0;
               k_nxt     = '0;
               if (lost_q != 8'hFF) lost_nxt = lost_q + 8'd1;
            end else if (bus.sw_rst_req) begin
               state_nxt = ST_ASSERT;
               cnt_nxt   = '0;
               k_nxt     = '0;
            end else if (state == ST_RELEASE) begin
               if (cnt == SD_LAST) begin
                  ch_rst_nxt[k] = 1'b0;
                  cnt_nxt       = '0;
                  if (k == K_LAST) begin
                     state_nxt = ST_RUN;
                     k_nxt     = '0;
                  end else begin
                     k_nxt = k + K_W'(1);
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = ST_ASSERT;
      endcase
      if (state_nxt == ST_ASSERT || state_nxt == ST_WAIT_LOCK) ch_rst_nxt = '1;
      seq_done_nxt = (state_nxt == ST_RUN);
   end

   assign bus.ch_rst        = ch_rst_q;
   assign bus.seq_done      = seq_done_q;
   assign bus.lock_lost_cnt = lost_q;
   assign bus.state_o       = state;
endmodule

// File: tb/tb_rst_seq_ctr.sv
// Bench for rst_seq_ctr: phase/elapsed-time reference model plus fixed milestone checks.
module tb_rst_seq_ctr;
   localparam int NUM_CH = 3;
   localparam int MA     = 16;
   localparam int LF     = 256;
   localparam int SD     = 64;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   rst_seq_ctr_if #(.NUM_CH(NUM_CH)) bus ();
   rst_seq_ctr_if #(.NUM_CH(NUM_CH)) if2 ();

   rst_seq_ctr #(.NUM_CH(NUM_CH), .MIN_ASSERT(MA), .LOCK_FILT(LF), .STEP_DLY(SD), .CNT_W(16)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

   rst_seq_ctr #(.NUM_CH(NUM_CH), .MIN_ASSERT(2), .LOCK_FILT(4), .STEP_DLY(2), .CNT_W(8)) dut2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if2));

   int vectors = 0;
   int miscompares = 0;
   int edge_n = 0;

   // Model: phase (0 assert, 1 wait, 2 release, 3 run) and cycles elapsed within it.
   int m_phase, m_t, m_cnt;
   bit m_s0, m_s1;

   logic [NUM_CH+10:0] act_vec;
   assign act_vec = {bus.ch_rst, bus.seq_done, bus.lock_lost_cnt, bus.state_o};

   task automatic model_reset();
      m_phase = 0; m_t = 0; m_cnt = 0; m_s0 = 0; m_s1 = 0; edge_n = 0;
   endtask

   task automatic model_step(input bit lk, input bit rq);
      bit ls;
      ls = m_s1;
      case (m_phase)
         0: if (rq) m_t = 0;
            else begin
               m_t++;
               if (m_t == MA) begin m_phase = 1; m_t = 0; end
            end
         1: if (rq) begin m_phase = 0; m_t = 0; end
            else if (ls) begin
               m_t++;
               if (m_t == LF) begin m_phase = 2; m_t = 0; end
            end else m_t = 0;
         default:
            if (!ls) begin
               m_phase = 0; m_t = 0;
               if (m_cnt < 255) m_cnt++;
            end else if (rq) begin
               m_phase = 0; m_t = 0;
            end else if (m_phase == 2) begin
               m_t++;
               if (m_t == NUM_CH * SD) m_phase = 3;
            end
      endcase
      m_s1 = m_s0;
      m_s0 = lk;
   endtask

   function automatic logic [NUM_CH+10:0] exp_vec();
      logic [NUM_CH-1:0] c;
      for (int i = 0; i < NUM_CH; i++) begin
         case (m_phase)
            2:       c[i] = (m_t < (i + 1) * SD);
            3:       c[i] = 1'b0;
            default: c[i] = 1'b1;
         endcase
      end
      return {c, (m_phase == 3), 8'(m_cnt), 2'(m_phase)};
   endfunction

   task automatic tick(input bit lk, input bit rq);
      bus.mmc_lock   = lk;
      bus.sw_rst_req = rq;
      @(posedge sys_clk);
      model_step(lk, rq);
      edge_n++;
      #1;
   endtask

   task automatic do_reset(input bit lk);
      sys_rst_n      = 1'b0;
      bus.mmc_lock   = lk;
      bus.sw_rst_req = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      model_reset();
      sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.mmc_lock = i[0];
         bus.sw_rst_req = i[1];
         @(posedge sys_clk);
         #1;
         if (act_vec !== {{NUM_CH{1'b1}}, 1'b0, 8'h00, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_values cyc %0d: got %h want %h", i, act_vec, {{NUM_CH{1'b1}}, 1'b0, 8'h00, 2'd0});
         end
         vectors++;
      end
   endtask

   task automatic test_nominal();
      int ms_e[10] = '{15, 16, 271, 272, 335, 336, 399, 400, 463, 464};
      int ms_s[10] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 3};
      int ms_c[10] = '{7, 7, 7, 7, 7, 6, 6, 4, 4, 0};
      do_reset(1'b1);
      for (int e = 1; e <= 470; e++) begin
         tick(1'b1, 1'b0);
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL nominal_model edge %0d: got %h want %h", edge_n, act_vec, exp_vec());
         end
         vectors++;
         for (int j = 0; j < 10; j++) begin
            if (e == ms_e[j]) begin
               if ({bus.ch_rst, bus.seq_done, bus.state_o} !== {NUM_CH'(ms_c[j]), ms_s[j] == 3, 2'(ms_s[j])}) begin
                  miscompares++;
                  $display("FAIL nominal_milestone edge %0d: got ch=%b done=%b st=%0d want ch=%b st=%0d",
                           e, bus.ch_rst, bus.seq_done, bus.state_o, NUM_CH'(ms_c[j]), ms_s[j]);
               end
               vectors++;
            end
         end
      end
   endtask

   task automatic test_glitch();
      do_reset(1'b1);
      repeat (216) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int e = 218; e <= 480; e++) begin
         tick(1'b1, 1'b0);
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL glitch_model edge %0d: got %h want %h", edge_n, act_vec, exp_vec());
         end
         vectors++;
         if (e == 474 || e == 475) begin
            if (bus.state_o !== ((e == 475) ? 2'd2 : 2'd1) || bus.lock_lost_cnt !== 8'd0) begin
               miscompares++;
               $display("FAIL glitch_refilter edge %0d: got st=%0d cnt=%0d", e, bus.state_o, bus.lock_lost_cnt);
            end
            vectors++;
         end
      end
   endtask

   task automatic test_lock_loss_run();
      do_reset(1'b1);
      repeat (470) tick(1'b1, 1'b0);
      for (int j = 1; j <= 3; j++) begin
         tick(1'b0, 1'b0);
         if ({bus.ch_rst, bus.seq_done, bus.lock_lost_cnt} !==
             ((j < 3) ? {{NUM_CH{1'b0}}, 1'b1, 8'd0} : {{NUM_CH{1'b1}}, 1'b0, 8'd1})) begin
            miscompares++;
            $display("FAIL lock_loss edge +%0d: got ch=%b done=%b cnt=%0d", j, bus.ch_rst, bus.seq_done, bus.lock_lost_cnt);
         end
         vectors++;
      end
      for (int e = 1; e <= 464; e++) begin
         tick(1'b1, 1'b0);
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL relock_model edge %0d: got %h want %h", edge_n, act_vec, exp_vec());
         end
         vectors++;
      end
      if (bus.seq_done !== 1'b1 || bus.state_o !== 2'd3) begin
         miscompares++;
         $display("FAIL relock_done: got done=%b st=%0d want 1/3", bus.seq_done, bus.state_o);
      end
      vectors++;
   endtask

   task automatic test_sw_req();
      tick(1'b1, 1'b1);
      if (bus.state_o !== 2'd0 || bus.lock_lost_cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL sw_req_run: got st=%0d cnt=%0d want 0/1", bus.state_o, bus.lock_lost_cnt);
      end
      vectors++;
      repeat (350) tick(1'b1, 1'b0);
      if (bus.ch_rst !== 3'b110 || bus.state_o !== 2'd2) begin
         miscompares++;
         $display("FAIL sw_req_setup: got ch=%b st=%0d want 110/2", bus.ch_rst, bus.state_o);
      end
      vectors++;
      tick(1'b1, 1'b1);
      if (act_vec !== {{NUM_CH{1'b1}}, 1'b0, 8'd1, 2'd0}) begin
         miscompares++;
         $display("FAIL sw_req_release: got %h want %h", act_vec, {{NUM_CH{1'b1}}, 1'b0, 8'd1, 2'd0});
      end
      vectors++;
      for (int e = 1; e <= 272; e++) begin
         tick(1'b1, 1'b0);
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL sw_req_model edge %0d: got %h want %h", edge_n, act_vec, exp_vec());
         end
         vectors++;
         if (e == 16 || e == 271 || e == 272) begin
            if (bus.state_o !== ((e == 272) ? 2'd2 : 2'd1)) begin
               miscompares++;
               $display("FAIL sw_req_rerun +%0d: got st=%0d", e, bus.state_o);
            end
            vectors++;
         end
      end
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      if (bus.lock_lost_cnt !== 8'd2 || bus.state_o !== 2'd0) begin
         miscompares++;
         $display("FAIL simultaneous_loss_req: got cnt=%0d st=%0d want 2/0", bus.lock_lost_cnt, bus.state_o);
      end
      vectors++;
   endtask

   task automatic test_random();
      bit lk = 1'b1;
      bit rq;
      for (int n = 0; n < 6000; n++) begin
         if (lk) lk = ($urandom_range(0, 699) != 0);
         else    lk = ($urandom_range(0, 2) == 0);
         rq = ($urandom_range(0, 499) == 0);
         tick(lk, rq);
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL random_model edge %0d: got %h want %h", edge_n, act_vec, exp_vec());
         end
         vectors++;
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      repeat (350) tick(1'b1, 1'b0);
      #3;
      sys_rst_n = 1'b0;
      #1;
      if (act_vec !== {{NUM_CH{1'b1}}, 1'b0, 8'h00, 2'd0}) begin
         miscompares++;
         $display("FAIL async_reset_immediate: got %h want %h", act_vec, {{NUM_CH{1'b1}}, 1'b0, 8'h00, 2'd0});
      end
      vectors++;
      repeat (2) @(posedge sys_clk);
      #1;
      model_reset();
      sys_rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick(1'b1, 1'b0);
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_restart_model edge %0d: got %h want %h", edge_n, act_vec, exp_vec());
         end
         vectors++;
      end
      if (bus.state_o !== 2'd1) begin
         miscompares++;
         $display("FAIL async_restart_wait: got st=%0d want 1", bus.state_o);
      end
      vectors++;
   endtask

   task automatic test_saturate();
      bit timed_out;
      if (if2.lock_lost_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL sat_start: got %0d want 0", if2.lock_lost_cnt);
      end
      vectors++;
      for (int i = 1; i <= 300; i++) begin
         if2.mmc_lock = 1'b1;
         timed_out = 1'b1;
         for (int n = 0; n < 40; n++) begin
            @(posedge sys_clk);
            #1;
            if (if2.state_o[1]) begin
               timed_out = 1'b0;
               break;
            end
         end
         if (timed_out) begin
            miscompares++;
            $display("FAIL sat_wait_release event %0d: got st=%0d want >=2", i, if2.state_o);
            break;
         end
         if2.mmc_lock = 1'b0;
         repeat (3) @(posedge sys_clk);
         #1;
         if (if2.lock_lost_cnt !== 8'((i > 255) ? 255 : i)) begin
            miscompares++;
            $display("FAIL sat_count event %0d: got %0d want %0d", i, if2.lock_lost_cnt, (i > 255) ? 255 : i);
         end
         vectors++;
      end
   endtask

   initial begin
      bus.mmc_lock   = 1'b0;
      bus.sw_rst_req = 1'b0;
      if2.mmc_lock   = 1'b0;
      if2.sw_rst_req = 1'b0;
      model_reset();
      test_reset();
      test_nominal();
      test_glitch();
      test_lock_loss_run();
      test_sw_req();
      test_random();
      test_async_reset();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
